// File: rtl/adaptive_signal_ctrl_if.sv
// rtl/adaptive_signal_ctrl_if.sv - signal bundle between the detector/time-base side and the signal controller
//
// Purpose: groups the tick/detector inputs and the light/status outputs of
// adaptive_signal_ctrl. The master modport drives tick and detect and observes
// the status; the slave modport is the controller.
//   tick      : one-cycle time-base enable
//   detect    : raw asynchronous detector level per approach
//   lights    : {red, yellow, green} per approach, approach i at [3i+2:3i]
//   state     : 0=ALL_RED, 1=GREEN, 2=YELLOW
//   phase     : approach owning green/yellow
//   time_left : ticks remaining in the current state
//   waiting   : queue count per approach, approach i at [CNT_W*i +: CNT_W]
interface adaptive_signal_ctrl_if #(
  parameter int N_APPR = 4,
  parameter int CNT_W  = 8,
  parameter int TIME_W = 6
);
  localparam int PH_W = (N_APPR > 1) ? $clog2(N_APPR) : 1;

  logic                      tick;
  logic [N_APPR-1:0]         detect;
  logic [3*N_APPR-1:0]       lights;
  logic [1:0]                state;
  logic [PH_W-1:0]           phase;
  logic [TIME_W-1:0]         time_left;
  logic [N_APPR*CNT_W-1:0]   waiting;

  modport master (
    output tick, detect,
    input  lights, state, phase, time_left, waiting
  );

  modport slave (
    input  tick, detect,
    output lights, state, phase, time_left, waiting
  );
endinterface

// File: rtl/adaptive_signal_ctrl.sv
// rtl/adaptive_signal_ctrl.sv - N-approach adaptive traffic-signal controller with per-approach queue counters
//
// Purpose: counts vehicles per approach from detector rising edges, serves
// approaches round-robin skipping empty queues, and sizes each green from the
// queue it serves (T_MIN + T_STEP*cars, capped at T_MAX). Rests in green when
// nobody else is waiting. Single clock, timing advanced by the tick enable.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : adaptive_signal_ctrl_if.slave (tick, detect in; lights, state,
//           phase, time_left, waiting out; all outputs registered)
module adaptive_signal_ctrl #(
  parameter int N_APPR = 4,
  parameter int CNT_W  = 8,
  parameter int TIME_W = 6,
  parameter int T_MIN  = 10,
  parameter int T_STEP = 2,
  parameter int T_MAX  = 40,
  parameter int T_YEL  = 4,
  parameter int T_RED  = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  adaptive_signal_ctrl_if.slave  bus
);
  localparam int PH_W  = (N_APPR > 1) ? $clog2(N_APPR) : 1;
  localparam int SUM_W = TIME_W + CNT_W + 1;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } state_t;

  logic [N_APPR-1:0]   sync1_q, sync2_q, prev_q, arrival, serve;
  logic [CNT_W-1:0]    cnt_q [N_APPR];
  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d, sel;
  logic [TIME_W-1:0]   tl_q, tl_d, g_time;
  logic [3*N_APPR-1:0] lights_q, lights_d;
  logic [SUM_W-1:0]    g_sum;
  logic                found, others_empty;
  int                  idx;

  // Detector path: 2-FF synchroniser, then edge detect against the previous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= bus.detect;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign arrival = sync2_q & ~prev_q;

  always_comb begin
    serve = '0;
    for (int i = 0; i < N_APPR; i++)
      serve[i] = (state_q == GREEN) && (phase_q == PH_W'(i)) && bus.tick && (cnt_q[i] != '0);
  end

  // Arrival and serve in the same cycle cancel; increment saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_APPR; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_APPR; i++) begin
        if (arrival[i] && !serve[i]) begin
          if (cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (serve[i] && !arrival[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  // Next approach: first non-empty queue after the current phase (wrapping back
  // to the current one last); with every queue empty, plain round-robin.
  always_comb begin
    sel          = '0;
    found        = 1'b0;
    idx          = 0;
    others_empty = 1'b1;
    for (int k = 1; k <= N_APPR; k++) begin
      idx = int'(phase_q) + k;
      if (idx >= N_APPR) idx = idx - N_APPR;
      if (k == 1) sel = PH_W'(idx);
      if (!found && cnt_q[idx] != '0) begin
        sel   = PH_W'(idx);
        found = 1'b1;
      end
    end
    for (int j = 0; j < N_APPR; j++)
      if (phase_q != PH_W'(j) && cnt_q[j] != '0) others_empty = 1'b0;
    // Widened so a long queue cannot wrap before the cap is applied.
    g_sum  = SUM_W'(T_MIN) + SUM_W'(T_STEP) * SUM_W'(cnt_q[sel]);
    g_time = (g_sum > SUM_W'(T_MAX)) ? TIME_W'(T_MAX) : g_sum[TIME_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ALL_RED;
      phase_q  <= '0;
      tl_q     <= TIME_W'(T_RED);
      lights_q <= {N_APPR{3'b100}};
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      tl_q     <= tl_d;
      lights_q <= lights_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tl_d    = tl_q;
    if (bus.tick) begin
      case (state_q)
        ALL_RED: begin
          if (tl_q > TIME_W'(1)) tl_d = tl_q - 1'b1;
          else begin
            state_d = GREEN;
            phase_d = sel;
            tl_d    = g_time;
          end
        end
        GREEN: begin
          if (tl_q > TIME_W'(1)) tl_d = tl_q - 1'b1;
          else if (others_empty) tl_d = TIME_W'(T_MIN);
          else begin
            state_d = YELLOW;
            tl_d    = TIME_W'(T_YEL);
          end
        end
        YELLOW: begin
          if (tl_q > TIME_W'(1)) tl_d = tl_q - 1'b1;
          else begin
            state_d = ALL_RED;
            tl_d    = TIME_W'(T_RED);
          end
        end
        default: begin
          state_d = ALL_RED;
          tl_d    = TIME_W'(T_RED);
        end
      endcase
    end
    // Lights follow the next state so they switch on the same edge as state.
    lights_d = {N_APPR{3'b100}};
    for (int i = 0; i < N_APPR; i++) begin
      if (phase_d == PH_W'(i) && state_d == GREEN)  lights_d[3*i +: 3] = 3'b001;
      if (phase_d == PH_W'(i) && state_d == YELLOW) lights_d[3*i +: 3] = 3'b010;
    end
  end

  assign bus.state     = state_q;
  assign bus.phase     = phase_q;
  assign bus.time_left = tl_q;
  assign bus.lights    = lights_q;

  always_comb begin
    bus.waiting = '0;
    for (int i = 0; i < N_APPR; i++) bus.waiting[CNT_W*i +: CNT_W] = cnt_q[i];
  end
endmodule

// File: tb/tb_adaptive_signal_ctrl.sv
// tb/tb_adaptive_signal_ctrl.sv - scoreboard bench for adaptive_signal_ctrl
module tb_adaptive_signal_ctrl;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adaptive_signal_ctrl_if #(.N_APPR(N), .CNT_W(CW), .TIME_W(TW)) sig_if ();

  adaptive_signal_ctrl #(
    .N_APPR(N), .CNT_W(CW), .TIME_W(TW),
    .T_MIN(10), .T_STEP(2), .T_MAX(40), .T_YEL(4), .T_RED(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sig_if)
  );

  typedef struct {
    string  tag;
    int     sel;
    int     idx;
    longint v;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint obs_of(input int sel, input int idx);
    case (sel)
      0: return longint'(sig_if.state);
      1: return longint'(sig_if.phase);
      2: return longint'(sig_if.time_left);
      3: return longint'(sig_if.lights);
      default: return longint'(sig_if.waiting[idx*CW +: CW]);
    endcase
  endfunction

  function automatic longint lights_for(input int st, input int ph);
    longint v = 0;
    for (int i = 0; i < N; i++) begin
      longint r = 4;
      if (i == ph && st == 1) r = 1;
      if (i == ph && st == 2) r = 2;
      v = v | (r << (3 * i));
    end
    return v;
  endfunction

  task automatic push(input string tag, input int sel, input int idx, input longint v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.idx = idx; e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic push_std(input string tag, input int st, input int ph, input int tl);
    push({tag, "_state"}, 0, 0, st);
    push({tag, "_phase"}, 1, 0, ph);
    push({tag, "_time"}, 2, 0, tl);
    push({tag, "_lights"}, 3, 0, lights_for(st, ph));
  endtask

  task automatic push_wait(input string tag, input int i, input int v);
    push($sformatf("%s_wait%0d", tag, i), 4, i, v);
  endtask

  task automatic drain;
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, obs_of(e.sel, e.idx), e.v);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    sig_if.tick = 1'b1;
    sig_if.detect = '0;
    repeat (3) @(negedge clk);
    sig_if.tick = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk) sig_if.tick = 1'b1;
      @(negedge clk) sig_if.tick = 1'b0;
    end
  endtask

  task automatic pulse(input int i);
    @(negedge clk) sig_if.detect[i] = 1'b1;
    @(negedge clk);
    @(negedge clk) sig_if.detect[i] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    sig_if.tick = 1'b0;
    sig_if.detect = '0;

    // Reset with tick held high, then idle round-robin and rest in green.
    do_reset();
    push_std("rst", 0, 0, 2);
    for (int i = 0; i < N; i++) push_wait("rst", i, 0);
    drain();
    tick_n(1);
    push_std("idle_red1", 0, 0, 1);
    drain();
    tick_n(1);
    push_std("idle_green", 1, 1, 10);
    drain();
    tick_n(9);
    push_std("idle_last", 1, 1, 1);
    drain();
    tick_n(1);
    push_std("rest_green", 1, 1, 10);
    drain();

    // Detector latency, then 5 cars on approach 2.
    do_reset();
    @(negedge clk) sig_if.detect[2] = 1'b1;
    @(posedge clk) #1 push_wait("lat_k", 2, 0);
    drain();
    @(posedge clk) #1 push_wait("lat_k1", 2, 0);
    drain();
    @(posedge clk) #1 push_wait("lat_k2", 2, 1);
    drain();
    @(negedge clk) sig_if.detect[2] = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 4; p++) pulse(2);
    push_wait("five", 2, 5);
    drain();
    tick_n(2);
    push_std("five_green", 1, 2, 20);
    drain();
    tick_n(5);
    push_std("five_served", 1, 2, 15);
    push_wait("five_served", 2, 0);
    drain();

    // 20 cars: green capped at T_MAX.
    do_reset();
    for (int p = 0; p < 20; p++) pulse(3);
    tick_n(2);
    push_std("cap", 1, 3, 40);
    push_wait("cap", 3, 20);
    drain();

    // Skip empty approaches 0 and 2 on the way from 1 to 3.
    do_reset();
    tick_n(2);
    push_std("skip_g1", 1, 1, 10);
    drain();
    for (int p = 0; p < 3; p++) pulse(3);
    tick_n(9);
    push_std("skip_g1_end", 1, 1, 1);
    drain();
    tick_n(1);
    push_std("skip_yel", 2, 1, 4);
    drain();
    tick_n(3);
    push_std("skip_yel_end", 2, 1, 1);
    drain();
    tick_n(1);
    push_std("skip_red", 0, 1, 2);
    drain();
    tick_n(1);
    push_std("skip_red_end", 0, 1, 1);
    drain();
    tick_n(1);
    push_std("skip_g3", 1, 3, 16);
    push_wait("skip_g3", 3, 3);
    drain();

    // Saturation, same-cycle arrival+serve, then async reset mid-yellow.
    do_reset();
    for (int p = 0; p < 300; p++) pulse(0);
    push_wait("sat", 0, 255);
    drain();
    tick_n(2);
    push_std("sat_green", 1, 0, 40);
    drain();
    tick_n(1);
    push_wait("serve1", 0, 254);
    drain();
    @(negedge clk) sig_if.detect[0] = 1'b1;
    @(negedge clk);
    @(negedge clk) sig_if.tick = 1'b1;
    @(negedge clk) begin sig_if.tick = 1'b0; sig_if.detect[0] = 1'b0; end
    push_wait("both", 0, 254);
    push_std("both", 1, 0, 38);
    drain();
    @(negedge clk);
    pulse(1);
    push_wait("other", 1, 1);
    drain();
    tick_n(38);
    push_std("sat_yel", 2, 0, 4);
    push_wait("sat_yel", 0, 216);
    drain();
    tick_n(1);
    push_std("sat_yel2", 2, 0, 3);
    drain();
    @(posedge clk) #3 rst_n = 1'b0;
    #1;
    push_std("async_rst", 0, 0, 2);
    for (int i = 0; i < N; i++) push_wait("async_rst", i, 0);
    drain();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
